// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared sizing helpers for the fifo controller and its fifo_mem users
//
// Purpose : single source for DEPTH and pointer width derived from ADDR_WIDTH.
// Contents: ADDR_WIDTH_DEFAULT, fifo_depth(), ptr_width().
package fifo_pkg;

  localparam int ADDR_WIDTH_DEFAULT = 4;

  // Number of storage entries addressed by an addr_width-bit address.
  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// rtl/fifo_ptr.sv - wrapping pointer counter used for the fifo write and read sides
//
// Purpose : WIDTH-bit pointer that advances by one on inc and wraps mod 2**WIDTH.
// Ports   : clk   - clock
//           rst   - asynchronous active-high reset, pointer -> 0
//           clr   - synchronous flush, pointer -> 0 (wins over inc)
//           inc   - advance pointer by one
//           ptr   - current pointer value
module fifo_ptr #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] ptr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - single-clock first-word-fall-through fifo controller for one fifo_mem
//
// Purpose : sequences fifo_mem addresses and write gating, tracks occupancy, and
//           produces registered full/empty/almost flags plus sticky error flags.
// Ports   : clk, rst (async active-high), clr (sync flush)
//           push, pop                         - producer/consumer requests
//           full, empty, almost_full,
//           almost_empty, count               - registered occupancy status
//           overflow, underflow               - sticky until clr or rst
//           mem_winc, mem_wfull,
//           mem_waddr, mem_raddr              - fifo_mem control
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
  parameter int AF_LEVEL   = 14,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  push,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  mem_winc,
  output logic                  mem_wfull,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [ADDR_WIDTH-1:0] mem_raddr
);

  localparam int PTR_W = ptr_width(ADDR_WIDTH);
  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] AF_C    = PTR_W'(AF_LEVEL);
  localparam logic [PTR_W-1:0] AE_C    = PTR_W'(AE_LEVEL);

  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] wptr_nxt;
  logic [PTR_W-1:0] rptr_nxt;
  logic [PTR_W-1:0] count_nxt;
  logic             wr_ok;
  logic             rd_ok;

  // Acceptance uses this cycle's registered flags, so there is no
  // combinational path from pop to full or from push to empty.
  assign wr_ok = push & ~full  & ~clr;
  assign rd_ok = pop  & ~empty & ~clr;

  fifo_ptr #(.WIDTH(PTR_W)) u_wptr (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (wr_ok),
    .ptr (wptr)
  );

  fifo_ptr #(.WIDTH(PTR_W)) u_rptr (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (rd_ok),
    .ptr (rptr)
  );

  // Next-state occupancy mirrors what the pointer counters will hold after
  // this edge, so count and flags land on the same edge as the pointers.
  assign wptr_nxt  = clr ? '0 : wptr + PTR_W'(wr_ok);
  assign rptr_nxt  = clr ? '0 : rptr + PTR_W'(rd_ok);
  assign count_nxt = wptr_nxt - rptr_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      count        <= count_nxt;
      full         <= (count_nxt == DEPTH_C);
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= AF_C);
      almost_empty <= (count_nxt <= AE_C);
      if (clr) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (push && full) begin
          overflow <= 1'b1;
        end
        if (pop && empty) begin
          underflow <= 1'b1;
        end
      end
    end
  end

  // fifo_mem gates its own write with wfull; clr suppresses the strobe outright.
  assign mem_winc  = push & ~clr;
  assign mem_wfull = full;
  assign mem_waddr = wptr[ADDR_WIDTH-1:0];
  assign mem_raddr = rptr[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb/tb_fifo_ctrl.sv - self-checking bench for fifo_ctrl with a queue-based reference model
module tb_fifo_ctrl;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;
  logic [4:0]  count;
  logic        overflow;
  logic        underflow;
  logic        mem_winc;
  logic        mem_wfull;
  logic [3:0]  mem_waddr;
  logic [3:0]  mem_raddr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] mem [0:15];

  int checks = 0;
  int errors = 0;
  bit run = 0;

  logic [31:0] q[$];
  bit m_ovf;
  bit m_unf;
  int wr_n;
  int rd_n;

  fifo_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .push         (push),
    .pop          (pop),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .mem_winc     (mem_winc),
    .mem_wfull    (mem_wfull),
    .mem_waddr    (mem_waddr),
    .mem_raddr    (mem_raddr)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Stand-in for fifo_mem: gated synchronous write, combinational read.
  always @(posedge clk) begin
    if (mem_winc && !mem_wfull) mem[mem_waddr] <= wdata;
  end
  assign rdata = mem[mem_raddr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0;
    m_unf = 0;
    wr_n  = 0;
    rd_n  = 0;
  endtask

  // One clock: drive requests, let the edge happen, advance the model,
  // and return just after the following negedge comparisons.
  task automatic cycle(input bit p, input bit r, input bit c, input logic [31:0] d);
    bit was_full;
    bit was_empty;
    push  = p;
    pop   = r;
    clr   = c;
    wdata = d;
    @(posedge clk);
    if (c) begin
      model_reset();
    end else begin
      was_full  = (q.size() == 16);
      was_empty = (q.size() == 0);
      if (r) begin
        if (was_empty) m_unf = 1;
        else begin
          void'(q.pop_front());
          rd_n++;
        end
      end
      if (p) begin
        if (was_full) m_ovf = 1;
        else begin
          q.push_back(d);
          wr_n++;
        end
      end
    end
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (run && !rst) begin
      check("count", 32'(count), 32'(q.size()));
      check("full", 32'(full), 32'(q.size() == 16));
      check("empty", 32'(empty), 32'(q.size() == 0));
      check("almost_full", 32'(almost_full), 32'(q.size() >= 14));
      check("almost_empty", 32'(almost_empty), 32'(q.size() <= 2));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("underflow", 32'(underflow), 32'(m_unf));
      check("mem_waddr", 32'(mem_waddr), 32'(wr_n % 16));
      check("mem_raddr", 32'(mem_raddr), 32'(rd_n % 16));
      check("mem_winc", 32'(mem_winc), 32'(push & ~clr));
      check("mem_wfull", 32'(mem_wfull), 32'(q.size() == 16));
      if (q.size() > 0) check("rdata_head", rdata, q[0]);
    end
  end

  initial begin
    rst   = 1;
    clr   = 0;
    push  = 0;
    pop   = 0;
    wdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ae", 32'(almost_empty), 32'd1);
    check("rst_af", 32'(almost_full), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    #1;
    rst = 0;
    run = 1;

    // Fill from empty to full, then one push too many.
    for (int i = 1; i <= 16; i++) begin
      cycle(1, 0, 0, 32'h100 + 32'(i));
      if (i == 13) check("af_at_13", 32'(almost_full), 32'd0);
      if (i == 14) check("af_at_14", 32'(almost_full), 32'd1);
    end
    check("fill_count", 32'(count), 32'd16);
    check("fill_full", 32'(full), 32'd1);
    push = 1;
    #1;
    check("no_write_when_full", 32'(mem_winc & ~mem_wfull), 32'd0);
    cycle(1, 0, 0, 32'hDEAD);
    check("ovf_after_17", 32'(overflow), 32'd1);
    check("count_after_17", 32'(count), 32'd16);

    // push&pop while full: only the pop is taken.
    cycle(1, 1, 0, 32'hBEEF);
    check("full_corner_count", 32'(count), 32'd15);
    check("full_corner_ovf", 32'(overflow), 32'd1);

    // Down to 9 with overflow still set, then flush with push&pop high.
    for (int i = 0; i < 6; i++) cycle(0, 1, 0, 32'h0);
    check("pre_clr_count", 32'(count), 32'd9);
    push = 1;
    pop  = 1;
    clr  = 1;
    #1;
    check("clr_no_winc", 32'(mem_winc), 32'd0);
    cycle(1, 1, 1, 32'h99);
    check("clr_count", 32'(count), 32'd0);
    check("clr_empty", 32'(empty), 32'd1);
    check("clr_ovf", 32'(overflow), 32'd0);
    check("clr_unf", 32'(underflow), 32'd0);

    // Fall-through drain order and underflow on an extra pop.
    for (int i = 1; i <= 3; i++) cycle(1, 0, 0, 32'hA5A5_0000 + 32'(i));
    check("drain_1", rdata, 32'hA5A5_0001);
    cycle(0, 1, 0, 32'h0);
    check("drain_2", rdata, 32'hA5A5_0002);
    cycle(0, 1, 0, 32'h0);
    check("drain_3", rdata, 32'hA5A5_0003);
    cycle(0, 1, 0, 32'h0);
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_unf_clear", 32'(underflow), 32'd0);
    cycle(0, 1, 0, 32'h0);
    check("drain_unf_set", 32'(underflow), 32'd1);

    // push&pop while empty: only the push is taken.
    cycle(0, 0, 1, 32'h0);
    check("unf_cleared", 32'(underflow), 32'd0);
    cycle(1, 1, 0, 32'h55);
    check("empty_corner_count", 32'(count), 32'd1);
    check("empty_corner_unf", 32'(underflow), 32'd1);
    check("empty_corner_data", rdata, 32'h55);

    // Hold occupancy at 8 while pointers wrap several times.
    for (int i = 0; i < 7; i++) cycle(1, 0, 0, 32'h200 + 32'(i));
    for (int i = 0; i < 40; i++) cycle(1, 1, 0, 32'h1000 + 32'(i));
    check("wrap_count", 32'(count), 32'd8);
    check("wrap_head", rdata, 32'h1000 + 32'd32);

    // Asynchronous reset in the middle of traffic.
    cycle(0, 0, 1, 32'h0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 32'h300 + 32'(i));
    check("pre_rst_count", 32'(count), 32'd5);
    #1;
    rst = 1;
    #1;
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_empty", 32'(empty), 32'd1);
    check("async_rst_full", 32'(full), 32'd0);
    check("async_rst_waddr", 32'(mem_waddr), 32'd0);
    check("async_rst_raddr", 32'(mem_raddr), 32'd0);
    model_reset();
    #1;
    rst = 0;
    cycle(1, 0, 0, 32'h77);
    check("post_rst_data", rdata, 32'h77);
    cycle(0, 0, 0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
